// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode encoding shared by the pipelined ALU and its core.
//                Opcode is {C1,C2,C3}; bit 2 and bit 1 both set marks the
//                arithmetic pair (ADD/SUB).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_NOR  = 3'b000;
    localparam alu_op_t OP_NAND = 3'b001;
    localparam alu_op_t OP_OR   = 3'b010;
    localparam alu_op_t OP_AND  = 3'b011;
    localparam alu_op_t OP_XOR  = 3'b100;
    localparam alu_op_t OP_XNOR = 3'b101;
    localparam alu_op_t OP_ADD  = 3'b110;
    localparam alu_op_t OP_SUB  = 3'b111;

    // True for ADD/SUB: the only ops that use or produce a carry.
    function automatic logic is_arith(input alu_op_t op);
        return op[2] & op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational WIDTH-bit ALU function block.
//  Ports       : a, b  - operands
//                op    - opcode (alu_op_t)
//                c     - carry-in, used by ADD/SUB only
//                res   - result
//                cout  - carry-out (0 for logic ops)
//                ovf   - signed overflow (0 for logic ops)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    input  logic             c,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    always_comb begin
        // SUB is a + ~b + c; plain subtraction relies on c = 1.
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c};
        res   = '0;
        cout  = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_NOR:  res = ~(a | b);
            OP_NAND: res = ~(a & b);
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_ADD, OP_SUB: begin
                res  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                // Operands of equal sign producing a result of the other sign.
                ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                       (sum[WIDTH-1] != a[WIDTH-1]);
            end
            default: res = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready on both sides,
//                status flags and a stored carry for multi-word chaining.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                in_valid/in_ready     - operation handshake
//                in_a, in_b, in_op     - operands and opcode
//                in_cin, in_chain      - carry-in / use stored carry
//                out_valid/out_ready   - result handshake
//                out_result            - result
//                out_cout, out_ovf     - carry-out, signed overflow
//                out_zero, out_neg     - result==0, result MSB
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_cin,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    // Stage 1: accepted operation
    logic             s1_v_q,     s1_v_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    alu_op_t          s1_op_q,    s1_op_d;
    logic             s1_cin_q,   s1_cin_d;
    logic             s1_chain_q, s1_chain_d;

    // Stage 2: computed result and flags
    logic             s2_v_q,     s2_v_d;
    logic [WIDTH-1:0] res_q,      res_d;
    logic             cout_q,     cout_d;
    logic             ovf_q,      ovf_d;
    logic             zero_q,     zero_d;
    logic             neg_q,      neg_d;

    logic             carry_q,    carry_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             c_eff;
    logic [WIDTH-1:0] core_res;
    logic             core_cout;
    logic             core_ovf;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .op   (s1_op_q),
        .c    (c_eff),
        .res  (core_res),
        .cout (core_cout),
        .ovf  (core_ovf)
    );

    always_comb begin
        s2_adv   = !s2_v_q || out_ready;
        s1_adv   = s1_v_q && s2_adv;
        in_ready = !s1_v_q || s2_adv;
        accept   = in_valid && in_ready;

        // carry_q is the carry of the most recent ADD/SUB to enter S2, so a
        // chained op directly behind it sees the fresh value without a bubble.
        c_eff    = s1_chain_q ? carry_q : s1_cin_q;

        s1_v_d     = s1_v_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_cin_d   = s1_cin_q;
        s1_chain_d = s1_chain_q;
        s2_v_d     = s2_v_q;
        res_d      = res_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        carry_d    = carry_q;

        if (accept) begin
            s1_v_d     = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = alu_op_t'(in_op);
            s1_cin_d   = in_cin;
            s1_chain_d = in_chain;
        end else if (s1_adv) begin
            s1_v_d     = 1'b0;
        end

        if (s1_adv) begin
            s2_v_d = 1'b1;
            res_d  = core_res;
            cout_d = core_cout;
            ovf_d  = core_ovf;
            zero_d = (core_res == '0);
            neg_d  = core_res[WIDTH-1];
            if (is_arith(s1_op_q)) begin
                carry_d = core_cout;
            end
        end else if (s2_adv) begin
            // Result drained with nothing behind it; data regs simply hold.
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_NOR;
            s1_cin_q   <= 1'b0;
            s1_chain_q <= 1'b0;
            s2_v_q     <= 1'b0;
            res_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s1_cin_q   <= s1_cin_d;
            s1_chain_q <= s1_chain_d;
            s2_v_q     <= s2_v_d;
            res_q      <= res_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            carry_q    <= carry_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign out_result = res_q;
    assign out_cout   = cout_q;
    assign out_ovf    = ovf_q;
    assign out_zero   = zero_q;
    assign out_neg    = neg_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe (WIDTH=16). Accepted ops
//                are modelled and queued; results are popped and compared
//                as they are consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         in_cin;
    logic         in_chain;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;
    logic         out_neg;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_cin     (in_cin),
        .in_chain   (in_chain),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero),
        .out_neg    (out_neg)
    );

    // {result, cout, ovf, zero, neg}
    typedef logic [W+3:0] exp_t;

    exp_t sb[$];
    logic m_carry;
    exp_t last_got;
    int   n_vec;
    int   n_err;

    function automatic exp_t model_calc(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic c);
        logic [W-1:0] r;
        logic [W-1:0] bb;
        logic [W:0]   u;
        logic         co;
        logic         ov;
        int           s;
        r  = '0;
        co = 1'b0;
        ov = 1'b0;
        bb = (op == 3'b111) ? ~b : b;
        case (op)
            3'b000:  r = ~(a | b);
            3'b001:  r = ~(a & b);
            3'b010:  r = a | b;
            3'b011:  r = a & b;
            3'b100:  r = a ^ b;
            3'b101:  r = ~(a ^ b);
            default: begin
                u  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
                r  = u[W-1:0];
                co = u[W];
                s  = int'($signed(a)) + int'($signed(bb)) + (c ? 1 : 0);
                ov = (s > 32767) || (s < -32768);
            end
        endcase
        return {r, co, ov, (r == '0), r[W-1]};
    endfunction

    // One clock: sample handshakes on the falling edge, return just after
    // the next rising edge.
    task automatic tick(output logic acc);
        exp_t got;
        exp_t e;
        logic c;
        @(negedge clk);
        acc = rst_n && in_valid && in_ready;
        if (rst_n && out_valid && out_ready) begin
            got = {out_result, out_cout, out_ovf, out_zero, out_neg};
            last_got = got;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL result: got %h, required no output", got);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL result: got %h, required %h", got, e);
                end
            end
        end
        if (acc) begin
            c = (in_chain && in_op[2] && in_op[1]) ? m_carry : in_cin;
            e = model_calc(in_op, in_a, in_b, c);
            if (in_op[2] && in_op[1]) m_carry = e[3];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic chain);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_chain = chain;
        for (int i = 0; i < 20; i++) begin
            tick(acc);
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
    endtask

    task automatic wait_drain();
        logic acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            tick(acc);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        logic acc;
        rst_n = 1'b0;
        tick(acc);
        tick(acc);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        n_vec++;
        if ({out_valid, out_result, out_cout, out_ovf, out_zero, out_neg} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b r=%h f=%b%b%b%b, required all 0",
                     out_valid, out_result, out_cout, out_ovf, out_zero, out_neg);
        end
    endtask

    task automatic test_and();
        logic acc;
        out_ready = 1'b1;
        send(OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL and_latency_early: out_valid got %b, required 0", out_valid);
        end
        tick(acc);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL and_latency: out_valid got %b, required 1", out_valid);
        end
        wait_drain();
        n_vec++;
        if (last_got !== {16'h00F0, 4'b0000}) begin
            n_err++;
            $display("FAIL and_value: got %h, required %h", last_got, {16'h00F0, 4'b0000});
        end
    endtask

    task automatic test_add_wrap();
        send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_drain();
        n_vec++;
        if (last_got !== {16'h0000, 4'b1010}) begin
            n_err++;
            $display("FAIL add_wrap: got %h, required %h", last_got, {16'h0000, 4'b1010});
        end
    endtask

    task automatic test_sub_ovf();
        send(OP_SUB, 16'h8000, 16'h0001, 1'b1, 1'b0);
        wait_drain();
        n_vec++;
        if (last_got !== {16'h7FFF, 4'b1100}) begin
            n_err++;
            $display("FAIL sub_ovf: got %h, required %h", last_got, {16'h7FFF, 4'b1100});
        end
    endtask

    task automatic test_chain();
        out_ready = 1'b1;
        send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(OP_ADD, 16'h0000, 16'h0000, 1'b0, 1'b1);
        wait_drain();
        n_vec++;
        if (last_got[W+3:4] !== 16'h0001) begin
            n_err++;
            $display("FAIL chain_hi: got %h, required 0001", last_got[W+3:4]);
        end
        // An XOR between the two halves must leave the stored carry alone.
        send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(OP_XOR, 16'h1234, 16'h00FF, 1'b0, 1'b1);
        send(OP_ADD, 16'h0000, 16'h0000, 1'b0, 1'b1);
        wait_drain();
        n_vec++;
        if (last_got[W+3:4] !== 16'h0001) begin
            n_err++;
            $display("FAIL chain_xor: got %h, required 0001", last_got[W+3:4]);
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        int   k;
        int   n_acc;
        logic [W+4:0] snap;
        out_ready = 1'b0;
        k         = 1;
        n_acc     = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = 1'b1;
            in_op    = OP_ADD;
            in_a     = W'(k);
            in_b     = '0;
            in_cin   = 1'b0;
            in_chain = 1'b0;
            tick(acc);
            if (acc) begin
                n_acc++;
                k++;
            end
        end
        n_vec++;
        if (n_acc != 2) begin
            n_err++;
            $display("FAIL bp_accepted: got %0d, required 2", n_acc);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_in_ready: got %b, required 0", in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_result !== 16'h0001) begin
            n_err++;
            $display("FAIL bp_head: got v=%b r=%h, required v=1 r=0001", out_valid, out_result);
        end
        snap = {out_valid, out_result, out_cout, out_ovf, out_zero, out_neg};
        for (int i = 0; i < 3; i++) tick(acc);
        n_vec++;
        if ({out_valid, out_result, out_cout, out_ovf, out_zero, out_neg} !== snap) begin
            n_err++;
            $display("FAIL bp_stable: got %h, required %h",
                     {out_valid, out_result, out_cout, out_ovf, out_zero, out_neg}, snap);
        end
        out_ready = 1'b1;
        send(OP_ADD, 16'h0003, 16'h0000, 1'b0, 1'b0);
        send(OP_ADD, 16'h0004, 16'h0000, 1'b0, 1'b0);
        wait_drain();
        n_vec++;
        if (last_got[W+3:4] !== 16'h0004) begin
            n_err++;
            $display("FAIL bp_last: got %h, required 0004", last_got[W+3:4]);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_op    = 3'($urandom_range(0, 7));
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'($urandom_range(0, 1));
            in_chain = 1'($urandom_range(0, 1));
            tick(acc);
            n_vec++;
            if (acc !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_accept[%0d]: got %b, required 1", i, acc);
            end
        end
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        logic acc;
        out_ready = 1'b0;
        send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_full: got v=%b rdy=%b, required v=1 rdy=0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async: out_valid got %b, required 0", out_valid);
        end
        sb.delete();
        m_carry   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(acc);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_hold: out_valid got %b, required 0", out_valid);
            end
        end
        rst_n = 1'b1;
        send(OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b1);
        wait_drain();
        n_vec++;
        if (last_got[W+3:4] !== 16'h0002) begin
            n_err++;
            $display("FAIL rst_carry: got %h, required 0002", last_got[W+3:4]);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_carry   = 1'b0;
        last_got  = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_cin    = 1'b0;
        in_chain  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_and();
        test_add_wrap();
        test_sub_ovf();
        test_chain();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
